// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle: master is the scan controller, slave is the
// pin/game-logic side that drives enable and columns and consumes key events.
interface keypad_scan_if;
   logic       scan_en;
   logic [3:0] keypad_col;
   logic [3:0] keypad_row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  scan_en, keypad_col,
      output keypad_row, key_code, key_valid, key_held
   );

   modport slave (
      output scan_en, keypad_col,
      input  keypad_row, key_code, key_valid, key_held
   );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row sequencer with synchronised column sampling, press/release
// debounce and a single-cycle key event per accepted press.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic          clk,
   input  logic          rst,
   keypad_scan_if.master kp
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE_CNT);
   localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   localparam logic [1:0] ST_SCAN     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_HELD     = 2'd2;

   localparam logic [3:0] ROW_FIRST = 4'b1110;
   localparam logic [3:0] COL_OPEN  = 4'b1111;
   // Nibble index is {rowIdx, colIdx}; row 0 holds 7,4,1,0 in column order.
   localparam logic [63:0] KEY_TABLE = 64'hFEDC_B369_A258_0147;

   logic [3:0]       colSync_p0;
   logic [3:0]       colSync_p1;
   logic [DIV_W-1:0] divCnt;
   logic             tick;
   logic [1:0]       state;
   logic [3:0]       row;
   logic [3:0]       candCol;
   logic [3:0]       candCode;
   logic [3:0]       code;
   logic [CNT_W-1:0] pressCnt;
   logic [CNT_W-1:0] relCnt;
   logic             valid;

   function automatic logic [3:0] rotateRow(input logic [3:0] r);
      case (r)
         4'b1110: rotateRow = 4'b1101;
         4'b1101: rotateRow = 4'b1011;
         4'b1011: rotateRow = 4'b0111;
         default: rotateRow = ROW_FIRST;
      endcase
   endfunction

   function automatic logic isSingle(input logic [3:0] c);
      case (c)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: isSingle = 1'b1;
         default:                            isSingle = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] lowIndex(input logic [3:0] v);
      case (v)
         4'b1110: lowIndex = 2'd0;
         4'b1101: lowIndex = 2'd1;
         4'b1011: lowIndex = 2'd2;
         default: lowIndex = 2'd3;
      endcase
   endfunction

   function automatic logic [3:0] keyDecode(input logic [3:0] r, input logic [3:0] c);
      int idx;
      idx = int'({lowIndex(r), lowIndex(c)});
      keyDecode = KEY_TABLE[idx*4 +: 4];
   endfunction

   // stage boundary: two-flop column synchroniser, col_s = colSync_p1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         colSync_p0 <= COL_OPEN;
         colSync_p1 <= COL_OPEN;
      end else begin
         colSync_p0 <= kp.keypad_col;
         colSync_p1 <= colSync_p0;
      end
   end

   assign tick = kp.scan_en && (divCnt == DIV_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  divCnt <= '0;
      else if (!kp.scan_en)     divCnt <= '0;
      else if (divCnt == DIV_LAST) divCnt <= '0;
      else                      divCnt <= divCnt + DIV_W'(1);
   end

   // A press is confirmed on the tick after the count fills, so the event
   // lands one dwell after the last matching sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_SCAN;
         row      <= ROW_FIRST;
         candCol  <= COL_OPEN;
         candCode <= 4'h0;
         code     <= 4'h0;
         pressCnt <= '0;
         relCnt   <= '0;
         valid    <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (!kp.scan_en) begin
            state    <= ST_SCAN;
            row      <= ROW_FIRST;
            pressCnt <= '0;
            relCnt   <= '0;
         end else if (tick) begin
            case (state)
               ST_SCAN: begin
                  if (isSingle(colSync_p1)) begin
                     candCode <= keyDecode(row, colSync_p1);
                     candCol  <= colSync_p1;
                     pressCnt <= CNT_W'(1);
                     state    <= ST_DEBOUNCE;
                  end else begin
                     row <= rotateRow(row);
                  end
               end
               ST_DEBOUNCE: begin
                  if (pressCnt >= CNT_FULL) begin
                     code     <= candCode;
                     valid    <= 1'b1;
                     pressCnt <= '0;
                     relCnt   <= '0;
                     state    <= ST_HELD;
                  end else if (colSync_p1 == candCol) begin
                     pressCnt <= pressCnt + CNT_W'(1);
                  end else begin
                     pressCnt <= '0;
                     row      <= rotateRow(row);
                     state    <= ST_SCAN;
                  end
               end
               ST_HELD: begin
                  if (colSync_p1 != COL_OPEN) begin
                     relCnt <= '0;
                  end else if (relCnt >= REL_LAST) begin
                     relCnt <= '0;
                     row    <= rotateRow(row);
                     state  <= ST_SCAN;
                  end else begin
                     relCnt <= relCnt + CNT_W'(1);
                  end
               end
               default: begin
                  state <= ST_SCAN;
                  row   <= ROW_FIRST;
               end
            endcase
         end
      end
   end

   assign kp.keypad_row = row;
   assign kp.key_code   = code;
   assign kp.key_valid  = valid;
   assign kp.key_held   = (state == ST_HELD);

endmodule
